// File: rtl/mouse_pkg.sv
// Shared types and default limits for the mouse controller configuration sequencer.
package mouse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_MAXX,
    WR_MAXY,
    WR_X,
    WR_Y,
    GAP,
    FIN
  } cfg_state_t;

  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_RC,
    PEND_FULL
  } pend_t;

  localparam logic [11:0] DEF_MAX_X      = 12'd799;
  localparam logic [11:0] DEF_MAX_Y      = 12'd599;
  localparam int          DEF_GAP_CYCLES = 2;

  // A full request always wins; a recenter only fills an empty slot.
  function automatic pend_t pend_merge(input pend_t cur, input logic full, input logic rc);
    if (full) return PEND_FULL;
    if (rc && cur == PEND_NONE) return PEND_RC;
    return cur;
  endfunction

endpackage

// File: rtl/mouse_cfg_seq.sv
// Writes X/Y limits and centre position into the PS/2 mouse controller with spaced strobes.
// Strobes, value, busy and done are registered; writes slip while the controller reports a packet.
module mouse_cfg_seq
  import mouse_pkg::*;
#(
  parameter logic [11:0] MAX_X      = DEF_MAX_X,
  parameter logic [11:0] MAX_Y      = DEF_MAX_Y,
  parameter int          GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic        clk100MHz,
  input  logic        rst,
  input  logic        start,
  input  logic        recenter,
  input  logic        new_event,
  output logic [11:0] value,
  output logic        setmax_x,
  output logic        setmax_y,
  output logic        setx,
  output logic        sety,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0]  GAP_LOAD = 4'(GAP_CYCLES - 1);
  localparam logic [11:0] CEN_X    = MAX_X >> 1;
  localparam logic [11:0] CEN_Y    = MAX_Y >> 1;

  cfg_state_t state, state_nxt;
  cfg_state_t wr_next, wr_next_nxt;
  pend_t      pend, pend_nxt;
  logic [3:0] gap_cnt;
  logic       boot, boot_req;
  logic       req_full, req_rc;

  always_comb begin
    req_full    = start | boot_req | (pend == PEND_FULL);
    req_rc      = recenter | (pend == PEND_RC);
    state_nxt   = state;
    wr_next_nxt = wr_next;
    pend_nxt    = pend_merge(pend, start | boot_req, recenter);
    case (state)
      IDLE, FIN: begin
        // A request seen together with new_event waits in the slot until the line is quiet.
        if ((req_full || req_rc) && !new_event) begin
          state_nxt = req_full ? WR_MAXX : WR_X;
          pend_nxt  = PEND_NONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      WR_MAXX: begin
        state_nxt   = GAP;
        wr_next_nxt = WR_MAXY;
      end
      WR_MAXY: begin
        state_nxt   = GAP;
        wr_next_nxt = WR_X;
      end
      WR_X: begin
        state_nxt   = GAP;
        wr_next_nxt = WR_Y;
      end
      WR_Y:    state_nxt = FIN;
      GAP: begin
        if (gap_cnt == 4'd0 && !new_event) state_nxt = wr_next;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_next  <= WR_MAXY;
      pend     <= PEND_NONE;
      gap_cnt  <= 4'd0;
      boot     <= 1'b1;
      boot_req <= 1'b0;
      value    <= 12'd0;
      setmax_x <= 1'b0;
      setmax_y <= 1'b0;
      setx     <= 1'b0;
      sety     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // The post-reset full sequence is presented as a request one cycle after release.
      boot     <= 1'b0;
      boot_req <= boot;
      state    <= state_nxt;
      wr_next  <= wr_next_nxt;
      pend     <= pend_nxt;
      if (state_nxt == GAP && state != GAP) gap_cnt <= GAP_LOAD;
      else if (state == GAP && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
      setmax_x <= (state_nxt == WR_MAXX);
      setmax_y <= (state_nxt == WR_MAXY);
      setx     <= (state_nxt == WR_X);
      sety     <= (state_nxt == WR_Y);
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == FIN);
      if (state_nxt == WR_MAXX)      value <= MAX_X;
      else if (state_nxt == WR_MAXY) value <= MAX_Y;
      else if (state_nxt == WR_X)    value <= CEN_X;
      else if (state_nxt == WR_Y)    value <= CEN_Y;
    end
  end

endmodule
